// File: rtl/riscv_soc_pkg.sv
// Shared SoC constants for the MEM-stage APB bridge: state encoding, peripheral window defaults
// and the APB data width.
package riscv_soc_pkg;

  localparam int unsigned APB_DATA_W = 32;

  localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h1000_0000;
  localparam logic [31:0] DEFAULT_PERIPH_MASK = 32'hFFFF_F000;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t StIdle   = 2'd0;
  localparam apb_state_t StSetup  = 2'd1;
  localparam apb_state_t StAccess = 2'd2;
  localparam apb_state_t StDone   = 2'd3;

endpackage

// File: rtl/riscv_apb_bridge.sv
// MEM-stage to APB3 master bridge; stalls the pipeline while a peripheral transfer is in flight.
// Optional ACCESS-phase watchdog enabled by defining RISCV_APB_TIMEOUT_EN.
module riscv_apb_bridge
  import riscv_soc_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = APB_DATA_W,
  parameter logic [ADDR_W-1:0] PERIPH_BASE    = ADDR_W'(DEFAULT_PERIPH_BASE),
  parameter logic [ADDR_W-1:0] PERIPH_MASK    = ADDR_W'(DEFAULT_PERIPH_MASK),
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              rdata_valid,
  output logic              bus_err,
  output logic              uart_stall,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_hit;

`ifdef RISCV_APB_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign req_hit = (mem_re | mem_we) & ((mem_addr & PERIPH_MASK) == PERIPH_BASE);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef RISCV_APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Store wins when both strobes are set.
        if (req_hit) begin
          paddr_d  = mem_addr;
          pwrite_d = mem_we;
          pwdata_d = mem_wdata;
          state_d  = StSetup;
        end
      end
      StSetup: begin
`ifdef RISCV_APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StAccess;
      end
      StAccess: begin
        if (pready) begin
          if (!pwrite_q) rdata_d = pslverr ? '0 : prdata;
          err_d   = pslverr;
          state_d = StDone;
        end
`ifdef RISCV_APB_TIMEOUT_EN
        // Abort on the TIMEOUT_CYCLES-th wait cycle; a same-cycle pready takes the branch above.
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef RISCV_APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef RISCV_APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign psel        = (state_q == StSetup) | (state_q == StAccess);
  assign penable     = (state_q == StAccess);
  assign rdata_valid = (state_q == StDone);
  assign bus_err     = (state_q == StDone) & err_q;
  // Low in DONE so the stalled instruction advances exactly once.
  assign uart_stall  = ((state_q == StIdle) & req_hit) | psel;

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_apb_bridge.sv
// Self-checking bench for riscv_apb_bridge: transaction-level model plus directed vectors.
module tb_riscv_apb_bridge;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_F000;
  localparam int          TO   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rdata_valid, bus_err, uart_stall;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;

  riscv_apb_bridge #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .PERIPH_BASE   (BASE),
    .PERIPH_MASK   (MASK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rdata_valid(rdata_valid),
    .bus_err    (bus_err),
    .uart_stall (uart_stall),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return (a & MASK) == BASE;
  endfunction

  // APB responder: pready rises after slave_waits low ACCESS cycles.
  int          slave_waits = 0;
  logic [31:0] slave_rdata = '0;
  logic        slave_err   = 1'b0;
  int          acc_cnt;

  always @(posedge clk) begin
    if (!rst_n) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready  = psel && penable && (acc_cnt >= slave_waits);
  assign prdata  = slave_rdata;
  assign pslverr = slave_err && pready;

  // Transaction model: k counts cycles since the IDLE-hit cycle (k=0); DONE is at k=m_end.
  bit          m_init = 0;
  bit          m_on   = 0;
  int          m_k, m_end;
  logic        m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_rd_exp;
  logic [31:0] m_rdata = '0;
  int          cyc = 0;
  bit          m_abort;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_init  <= 1;
      m_on    <= 0;
      m_rdata <= '0;
    end else if (m_on) begin
      if (m_k == m_end) begin
        m_on    <= 0;
        m_rdata <= m_rd_exp;
      end else begin
        m_k <= m_k + 1;
      end
    end else if ((mem_re || mem_we) && is_hit(mem_addr)) begin
`ifdef RISCV_APB_TIMEOUT_EN
      m_abort = (slave_waits >= TO);
`else
      m_abort = 0;
`endif
      m_on     <= 1;
      m_k      <= 1;
      m_we     <= mem_we;
      m_addr   <= mem_addr;
      m_wdata  <= mem_wdata;
      m_end    <= m_abort ? 2 + TO : 3 + slave_waits;
      m_err    <= m_abort ? 1'b1 : slave_err;
      m_rd_exp <= m_abort ? 32'h0 : (mem_we ? m_rdata : (slave_err ? 32'h0 : slave_rdata));
    end
  end

  logic        e_stall, e_psel, e_pen, e_val, e_err;
  int          stall_cnt, psel_cnt, pen_cnt, valid_cnt;
  int          done_cyc, last_setup_cyc;
  logic [31:0] cap_rdata, cap_pwdata;
  logic        cap_err;

  always @(negedge clk) begin
    if (m_init) begin
      e_stall = m_on ? (m_k < m_end) : ((mem_re || mem_we) && is_hit(mem_addr));
      e_psel  = m_on && (m_k < m_end);
      e_pen   = m_on && (m_k >= 2) && (m_k < m_end);
      e_val   = m_on && (m_k == m_end);
      e_err   = e_val && m_err;
      check("ctl{stall,psel,penable,valid,err}", {uart_stall, psel, penable, rdata_valid, bus_err},
            {e_stall, e_psel, e_pen, e_val, e_err});
      if (e_psel) check("apb{paddr,pwrite,pwdata}", {paddr, pwrite, pwdata},
                        {m_addr, m_we, m_wdata});
      if (e_val) check("mem_rdata", mem_rdata, m_rd_exp);
      stall_cnt += int'(uart_stall === 1'b1);
      psel_cnt  += int'(psel === 1'b1);
      pen_cnt   += int'(penable === 1'b1);
      if (psel === 1'b1) cap_pwdata = pwdata;
      if (psel === 1'b1 && penable === 1'b0) last_setup_cyc = cyc;
      if (rdata_valid === 1'b1) begin
        valid_cnt++;
        cap_rdata = mem_rdata;
        cap_err   = bus_err;
        done_cyc  = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_re = re;
    mem_we = we;
    mem_addr = a;
    mem_wdata = d;
  endtask

  task automatic set_slave(input int w, input logic [31:0] rd, input logic e);
    slave_waits = w;
    slave_rdata = rd;
    slave_err = e;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0;
    psel_cnt = 0;
    pen_cnt = 0;
    valid_cnt = 0;
  endtask

  // Hold the request until DONE, scrambling mem_* once mid-transfer; ends in the next cycle.
  task automatic wait_done();
    int n = 0;
    while (rdata_valid !== 1'b1 && n < 300) begin
      step();
      n++;
      if (n == 1) begin
        mem_addr  = mem_addr ^ 32'h0000_0040;
        mem_wdata = ~mem_wdata;
      end
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL done_wait: rdata_valid not seen within %0d cycles", n);
    end
    step();
  endtask

  initial begin
    int d1, n;
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    set_slave(0, 32'h0, 0);
    clr_cnt();
    repeat (3) step();
    check("reset_ctl", {psel, penable, pwrite, rdata_valid, bus_err, uart_stall}, 6'b0);
    check("reset_regs", {paddr, pwdata, mem_rdata}, 96'h0);
    rst_n = 1'b1;
    step();

    // Zero-wait write
    set_slave(0, 32'hDEAD_BEEF, 0);
    clr_cnt();
    drive(0, 1, 32'h1000_0004, 32'h0000_00A5);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t1_stall_cycles", stall_cnt, 3);
    check("t1_psel_cycles", psel_cnt, 2);
    check("t1_penable_cycles", pen_cnt, 1);
    check("t1_pwdata", cap_pwdata, 32'h0000_00A5);
    check("t1_valid_err", {valid_cnt[7:0], cap_err}, {8'd1, 1'b0});
    step();

    // Read with two wait states
    set_slave(2, 32'h1234_5678, 0);
    clr_cnt();
    drive(1, 0, 32'h1000_0010, 32'h0);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t2_stall_cycles", stall_cnt, 5);
    check("t2_rdata", cap_rdata, 32'h1234_5678);
    step();

    // Non-peripheral accesses, including the first address past the window
    clr_cnt();
    drive(1, 0, 32'h0000_0100, 32'h0);
    step();
    drive(0, 1, 32'h1000_1000, 32'h1111_1111);
    step();
    drive(1, 1, 32'h0FFF_FFFC, 32'h2222_2222);
    step();
    drive(0, 0, 32'h0, 32'h0);
    step();
    check("t3_no_activity", {psel_cnt[7:0], stall_cnt[7:0], valid_cnt[7:0]}, 24'h0);

    // Both strobes at the top of the window: treated as a write, one wait state
    set_slave(1, 32'h9999_9999, 0);
    clr_cnt();
    drive(1, 1, 32'h1000_0FFC, 32'h0BAD_CAFE);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t4_stall_cycles", stall_cnt, 4);
    check("t4_write_keeps_rdata", cap_rdata, 32'h1234_5678);
    step();

    // Errored read, then a back-to-back read
    set_slave(0, 32'hCAFE_F00D, 1);
    clr_cnt();
    drive(1, 0, 32'h1000_0020, 32'h0);
    wait_done();
    d1 = done_cyc;
    check("t5_err_read", {cap_err, cap_rdata}, {1'b1, 32'h0});
    set_slave(1, 32'h5555_AAAA, 0);
    drive(1, 0, 32'h1000_0024, 32'h0);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t5_b2b_setup_gap", last_setup_cyc - d1, 2);
    check("t5_second_read", {cap_err, cap_rdata}, {1'b0, 32'h5555_AAAA});
    step();

    // Reset during ACCESS
    set_slave(100, 32'h7777_0000, 0);
    clr_cnt();
    drive(1, 0, 32'h1000_0030, 32'h0);
    n = 0;
    while (!(psel === 1'b1 && penable === 1'b1) && n < 10) begin
      step();
      n++;
    end
    check("t6_reached_access", {psel, penable}, 2'b11);
    step();
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    step();
    check("t6_reset_mid", {psel, penable, uart_stall, rdata_valid, mem_rdata}, 36'h0);
    rst_n = 1'b1;
    step();
    step();
    check("t6_no_valid", valid_cnt, 0);

`ifdef RISCV_APB_TIMEOUT_EN
    // Timeout abort, then pready exactly on the expiry cycle
    set_slave(100, 32'h7777_7777, 0);
    clr_cnt();
    drive(1, 0, 32'h1000_0040, 32'h0);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t7_abort_stall", stall_cnt, 6);
    check("t7_abort", {cap_err, cap_rdata}, {1'b1, 32'h0});
    step();
    set_slave(3, 32'h3C3C_3C3C, 0);
    clr_cnt();
    drive(1, 0, 32'h1000_0044, 32'h0);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t7_edge_stall", stall_cnt, 6);
    check("t7_edge_ok", {cap_err, cap_rdata}, {1'b0, 32'h3C3C_3C3C});
`else
    // Without the watchdog a long wait completes normally
    set_slave(20, 32'h3C3C_3C3C, 0);
    clr_cnt();
    drive(1, 0, 32'h1000_0044, 32'h0);
    wait_done();
    drive(0, 0, 32'h0, 32'h0);
    check("t7_long_stall", stall_cnt, 23);
    check("t7_long_ok", {cap_err, cap_rdata}, {1'b0, 32'h3C3C_3C3C});
`endif
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
